spi_slave_frame_ctrl: RTL

//  Parametrised SPI slave frame controller: next generation of the fixed 10-bit slave.

---
 rtl/spi_slave_frame_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/spi_slave_frame_ctrl.sv
// spi_slave_frame_ctrl: SPI slave that deserialises {cmd, payload} frames, checks cmd/state
// consistency, and serialises RAM read data back on MISO with a tx_valid timeout.
module spi_slave_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rd_pending,
  output logic              frame_err
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam int TW      = $clog2(TX_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT, DONE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                rd_pending_q, rd_pending_d, miso_q, miso_d;
  logic [1:0]          cmd;
  logic                shifting, legal;
  assign cmd      = rx_data_q[FRAME_W-1 -: 2];
  assign shifting = state_q inside {WRITE, READ_ADD, READ_DATA};
  assign legal    = (state_q == WRITE && !cmd[1]) || (state_q == READ_ADD && cmd == 2'b10) ||
                    (state_q == READ_DATA && cmd == 2'b11);
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = '0;
    rx_data_d    = rx_data_q;
    shreg_d      = shreg_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    rd_pending_d = rd_pending_q;
    miso_d       = miso_q;
    // Deselect wins over everything; only an incomplete or in-flight frame is an error.
    if (state_q != IDLE && SS_n) begin
      state_d     = IDLE;
      miso_d      = 1'b0;
      frame_err_d = state_q == CHK_CMD || (shifting && cnt_q != '0) ||
                    state_q == WAIT_TX || state_q == SHIFT_OUT;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d  = 1'b0;
          state_d = SS_n ? IDLE : CHK_CMD;
        end
        CHK_CMD: begin
          rx_data_d[FRAME_W-1] = MOSI;
          cnt_d                = CW'(FRAME_W - 1);
          state_d              = !MOSI ? WRITE : rd_pending_q ? READ_DATA : READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q != '0) begin
            rx_data_d[cnt_q - CW'(1)] = MOSI;
            cnt_d                     = cnt_q - CW'(1);
          end else begin
            rx_valid_d   = legal;
            frame_err_d  = !legal;
            rd_pending_d = (legal && state_q == READ_ADD) ? 1'b1 : rd_pending_q;
            state_d      = (legal && state_q == READ_DATA) ? WAIT_TX : DONE;
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            shreg_d = tx_data;
            cnt_d   = CW'(DATA_W);
            state_d = SHIFT_OUT;
          end else if (timer_q == TW'(TX_TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            state_d     = DONE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SHIFT_OUT: begin
          miso_d  = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rd_pending_d = 1'b0;
            state_d      = DONE;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      rx_data_q    <= '0;
      shreg_q      <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      rx_data_q    <= rx_data_d;
      shreg_q      <= shreg_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      rd_pending_q <= rd_pending_d;
      miso_q       <= miso_d;
    end
  end
  assign MISO       = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign rd_pending = rd_pending_q;
endmodule
